// File: rtl/trdb_pkg.sv
// trdb_pkg: shared types and register map for the trace debugger control path.
//   trdb_cfg_op_e    : command opcodes accepted by trdb_cfg_master
//   trdb_cfg_state_e : trdb_cfg_master FSM states
//   REG_TRDB_*       : per_* register addresses of trdb_reg
//   cfg_poll_match   : masked compare used by POLL commands
package trdb_pkg;

  localparam int TRDB_ADDR_WIDTH = 12;

  localparam logic [TRDB_ADDR_WIDTH-1:0] REG_TRDB_CTRL   = 12'h000;
  localparam logic [TRDB_ADDR_WIDTH-1:0] REG_TRDB_STATUS = 12'h004;
  localparam logic [TRDB_ADDR_WIDTH-1:0] REG_TRDB_FILTER = 12'h008;
  localparam logic [TRDB_ADDR_WIDTH-1:0] REG_TRDB_DUMP   = 12'h00C;

  typedef enum logic [1:0] {
    CFG_WRITE = 2'b00,
    CFG_READ  = 2'b01,
    CFG_POLL  = 2'b10,
    CFG_RSVD  = 2'b11
  } trdb_cfg_op_e;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'b00,
    CFG_ACCESS = 2'b01,
    CFG_GAP    = 2'b10,
    CFG_RESP   = 2'b11
  } trdb_cfg_state_e;

  function automatic logic cfg_poll_match(input logic [31:0] rdata,
                                          input logic [31:0] expected,
                                          input logic [31:0] mask);
    return ((rdata & mask) == (expected & mask));
  endfunction

endpackage

// File: rtl/trdb_cfg_master.sv
// trdb_cfg_master: bus initiator for the trace debugger control registers.
// Converts WRITE / READ / POLL commands into single per_* transactions and
// returns read data plus error status on a valid/ready response channel.
//
//   state  | meaning
//   IDLE   | cmd_ready_o=1, waiting for a command
//   ACCESS | per_valid_o=1, waiting for per_ready_i or timeout
//   GAP    | one idle bus cycle between POLL reads
//   RESP   | rsp_valid_o=1, waiting for rsp_ready_i
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   cmd_valid_i / cmd_ready_o / cmd_op_i / cmd_addr_i / cmd_wdata_i / cmd_mask_i
//   rsp_valid_o / rsp_ready_i / rsp_rdata_o / rsp_err_o
//   busy_o
//   per_valid_o / per_we_o / per_addr_o / per_wdata_o / per_rdata_i / per_ready_i
module trdb_cfg_master
  import trdb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int POLL_MAX       = 1024,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  input  logic [31:0]               cmd_mask_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic                      per_valid_o,
  output logic                      per_we_o,
  output logic [APB_ADDR_WIDTH-1:0] per_addr_o,
  output logic [31:0]               per_wdata_o,
  input  logic [31:0]               per_rdata_i,
  input  logic                      per_ready_i
);

  // Counter widths are clamped to 1 so degenerate parameter values still elaborate.
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  trdb_cfg_state_e           state_q, state_d;
  trdb_cfg_op_e              op_q, op_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [31:0]               mask_q, mask_d;
  logic [WW-1:0]             wait_q, wait_d;
  logic [PW-1:0]             poll_q, poll_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      per_valid_q, per_valid_d;
  logic                      per_we_q, per_we_d;
  logic                      rsp_valid_q, rsp_valid_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    wait_d  = wait_q;
    poll_d  = poll_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      CFG_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = trdb_cfg_op_e'(cmd_op_i);
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          mask_d  = cmd_mask_i;
          wait_d  = '0;
          poll_d  = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          if (trdb_cfg_op_e'(cmd_op_i) == CFG_RSVD) begin
            err_d   = 1'b1;
            state_d = CFG_RESP;
          end else begin
            state_d = CFG_ACCESS;
          end
        end
      end

      CFG_ACCESS: begin
        // Ready is evaluated before the timeout so a completion on the last
        // allowed cycle is not reported as an error.
        if (per_ready_i) begin
          unique case (op_q)
            CFG_WRITE: begin
              state_d = CFG_RESP;
            end
            CFG_READ: begin
              rdata_d = per_rdata_i;
              state_d = CFG_RESP;
            end
            CFG_POLL: begin
              rdata_d = per_rdata_i;
              if (cfg_poll_match(per_rdata_i, wdata_q, mask_q)) begin
                state_d = CFG_RESP;
              end else if (poll_q == POLL_LAST) begin
                err_d   = 1'b1;
                state_d = CFG_RESP;
              end else begin
                poll_d  = poll_q + 1'b1;
                state_d = CFG_GAP;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = CFG_RESP;
            end
          endcase
        end else if (wait_q == WAIT_LAST) begin
          // rdata keeps 0 or the value captured by the previous POLL read.
          err_d   = 1'b1;
          state_d = CFG_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      CFG_GAP: begin
        // Idle bus cycle lets the responder's combinational status settle.
        wait_d  = '0;
        state_d = CFG_ACCESS;
      end

      CFG_RESP: begin
        if (rsp_ready_i) begin
          state_d = CFG_IDLE;
        end
      end

      default: begin
        state_d = CFG_IDLE;
      end
    endcase

    // Outputs are registered copies of the next state, so they change on the
    // same edge as the state itself.
    per_valid_d = (state_d == CFG_ACCESS);
    per_we_d    = (state_d == CFG_ACCESS) && (op_d == CFG_WRITE);
    rsp_valid_d = (state_d == CFG_RESP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= CFG_IDLE;
      op_q        <= CFG_WRITE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      wait_q      <= '0;
      poll_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      per_valid_q <= 1'b0;
      per_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      wait_q      <= wait_d;
      poll_q      <= poll_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      per_valid_q <= per_valid_d;
      per_we_q    <= per_we_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready_o = (state_q == CFG_IDLE);
  assign busy_o      = (state_q != CFG_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign per_valid_o = per_valid_q;
  assign per_we_o    = per_we_q;
  assign per_addr_o  = addr_q;
  assign per_wdata_o = wdata_q;

endmodule

// File: tb/tb_trdb_cfg_master.sv
// Directed bench for trdb_cfg_master with a small trdb_reg-like responder:
// CTRL stores written bits [2:0]; bit 2 (flush) reads back as 1 until five
// CTRL reads have completed since flush_base. STATUS returns
// {16'h0, status read count[7:0], 7'h0, qualified}.
module tb_trdb_cfg_master;
  import trdb_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [31:0]   cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          per_valid;
  logic          per_we;
  logic [AW-1:0] per_addr;
  logic [31:0]   per_wdata;
  logic [31:0]   per_rdata;
  logic          ready_en = 1'b1;
  logic          qualified = 1'b1;

  trdb_cfg_master #(
    .APB_ADDR_WIDTH(AW),
    .POLL_MAX(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .busy_o(busy),
    .per_valid_o(per_valid),
    .per_we_o(per_we),
    .per_addr_o(per_addr),
    .per_wdata_o(per_wdata),
    .per_rdata_i(per_rdata),
    .per_ready_i(ready_en)
  );

  always #5 clk = ~clk;

  // Responder state and bus monitors
  logic [31:0]   ctrl_reg = '0;
  int            ctrl_reads = 0;
  int            status_reads = 0;
  int            flush_base = 0;
  int            writes = 0;
  int            pulses = 0;
  int            valid_cycles = 0;
  int            we_viol = 0;
  logic          prev_valid = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          last_we = 1'b0;
  logic [31:0]   last_wdata = '0;

  always_comb begin
    per_rdata = 32'hBAD0_0000;
    if (per_addr == REG_TRDB_CTRL)
      per_rdata = {29'h0, ctrl_reg[2] && ((ctrl_reads - flush_base) < 5), ctrl_reg[1:0]};
    else if (per_addr == REG_TRDB_STATUS)
      per_rdata = {16'h0, status_reads[7:0], 7'h0, qualified};
  end

  always @(posedge clk) begin
    prev_valid <= per_valid;
    if (per_valid) valid_cycles <= valid_cycles + 1;
    if (per_valid && !prev_valid) pulses <= pulses + 1;
    if (per_valid && ready_en) begin
      last_addr <= per_addr;
      last_we   <= per_we;
      if (per_we) begin
        writes     <= writes + 1;
        last_wdata <= per_wdata;
        if (per_addr == REG_TRDB_CTRL) ctrl_reg <= per_wdata & 32'h7;
      end else if (per_addr == REG_TRDB_CTRL) begin
        ctrl_reads <= ctrl_reads + 1;
      end else if (per_addr == REG_TRDB_STATUS) begin
        status_reads <= status_reads + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!per_valid && per_we) we_viol <= we_viol + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [31:0] mk, input string tag,
                          output int lat, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_mask  = mk;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_back_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          p0, w0, r0, v0, base;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_per_valid", 32'(per_valid), 32'd0);
    chk("rst_per_we", 32'(per_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;

    // WRITE CTRL = 3
    p0 = pulses; w0 = writes;
    send_cmd(2'b00, REG_TRDB_CTRL, 32'h3, 32'h0, "wr_ctrl", lat, rd, er);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_pulses", 32'(pulses - p0), 32'd1);
    chk("wr_count", 32'(writes - w0), 32'd1);
    chk("wr_addr", 32'(last_addr), 32'(REG_TRDB_CTRL));
    chk("wr_we", 32'(last_we), 32'd1);
    chk("wr_wdata", last_wdata, 32'h3);

    // READ CTRL
    send_cmd(2'b01, REG_TRDB_CTRL, 32'h0, 32'h0, "rd_ctrl", lat, rd, er);
    chk("rd_ctrl_data", rd & 32'h3, 32'h3);
    chk("rd_ctrl_err", 32'(er), 32'd0);
    chk("rd_ctrl_lat", 32'(lat), 32'd2);

    // READ STATUS, qualified=1, no earlier status reads
    send_cmd(2'b01, REG_TRDB_STATUS, 32'h0, 32'h0, "rd_stat", lat, rd, er);
    chk("rd_stat_qual", 32'(rd[0]), 32'd1);
    chk("rd_stat_data", rd, 32'h0000_0001);
    chk("rd_stat_err", 32'(er), 32'd0);

    // Set flush, then POLL CTRL until flush clears (sixth read matches)
    send_cmd(2'b00, REG_TRDB_CTRL, 32'h7, 32'h0, "wr_flush", lat, rd, er);
    flush_base = ctrl_reads;
    p0 = pulses; r0 = ctrl_reads;
    send_cmd(2'b10, REG_TRDB_CTRL, 32'h0, 32'h4, "poll_flush", lat, rd, er);
    chk("poll_flush_err", 32'(er), 32'd0);
    chk("poll_flush_reads", 32'(ctrl_reads - r0), 32'd6);
    chk("poll_flush_pulses", 32'(pulses - p0), 32'd6);
    chk("poll_flush_lat", 32'(lat), 32'd12);
    chk("poll_flush_rdata", rd, 32'h3);

    // POLL STATUS never matching: POLL_MAX=8 reads, last value returned
    base = status_reads;
    r0 = status_reads; p0 = pulses;
    send_cmd(2'b10, REG_TRDB_STATUS, 32'hDEAD, 32'hFFFF_FFFF, "poll_exh", lat, rd, er);
    chk("poll_exh_err", 32'(er), 32'd1);
    chk("poll_exh_reads", 32'(status_reads - r0), 32'd8);
    chk("poll_exh_pulses", 32'(pulses - p0), 32'd8);
    chk("poll_exh_lat", 32'(lat), 32'd16);
    chk("poll_exh_rdata", rd, {16'h0, 8'(base + 7), 7'h0, 1'b1});

    // Timeout: responder never ready, TIMEOUT_CYCLES=8
    ready_en = 1'b0;
    p0 = pulses; v0 = valid_cycles;
    send_cmd(2'b01, REG_TRDB_CTRL, 32'h0, 32'h0, "tmo", lat, rd, er);
    chk("tmo_err", 32'(er), 32'd1);
    chk("tmo_rdata", rd, 32'd0);
    chk("tmo_valid_cycles", 32'(valid_cycles - v0), 32'd8);
    chk("tmo_pulses", 32'(pulses - p0), 32'd1);
    chk("tmo_lat", 32'(lat), 32'd9);
    ready_en = 1'b1;

    // Next command proceeds normally
    base = status_reads;
    send_cmd(2'b01, REG_TRDB_STATUS, 32'h0, 32'h0, "after_tmo", lat, rd, er);
    chk("after_tmo_err", 32'(er), 32'd0);
    chk("after_tmo_lat", 32'(lat), 32'd2);
    chk("after_tmo_data", rd, {16'h0, 8'(base), 7'h0, 1'b1});

    // Reserved op: no bus access, error response
    p0 = pulses;
    send_cmd(2'b11, REG_TRDB_CTRL, 32'h5, 32'h0, "rsvd", lat, rd, er);
    chk("rsvd_err", 32'(er), 32'd1);
    chk("rsvd_rdata", rd, 32'd0);
    chk("rsvd_pulses", 32'(pulses - p0), 32'd0);
    chk("rsvd_lat", 32'(lat), 32'd1);

    // Reset while in ACCESS
    ready_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_addr  = REG_TRDB_CTRL;
    begin
      int n;
      n = 0;
      while (!per_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mid_access_valid", 32'(per_valid), 32'd1);
    cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_per_valid", 32'(per_valid), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_en = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_per_valid", 32'(per_valid), 32'd0);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    chk("we_only_with_valid", 32'(we_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
